// File: rtl/wsc_mapper_pkg.sv
// Shared constants for the WonderSwan-class cartridge mapper: register map, CTRL bits,
// default unlock sequence and boot bitstream.
package wsc_mapper_pkg;

  localparam int unsigned RegLao  = 0;
  localparam int unsigned RegRam  = 1;
  localparam int unsigned RegRom0 = 2;

  localparam int unsigned CtrlWp     = 0;
  localparam int unsigned CtrlRelock = 1;

  localparam int unsigned DefUnlockLen = 2;
  localparam logic [15:0] DefUnlockSeq = {8'hA5, 8'h5A};

  localparam int unsigned DefBsLen = 18;
  localparam logic [17:0] DefBsPat = {1'b0, 16'h28A0, 1'b0};

  typedef enum logic [0:0] {
    StLocked,
    StOpen
  } unlock_state_e;

endpackage

// File: rtl/wsc_unlock_seq.sv
// Address-match unlock sequencer; loads the boot bitstream on unlock and shifts it out
// LSB first, back-filling with ones.
module wsc_unlock_seq
  import wsc_mapper_pkg::*;
#(
  parameter int unsigned                  UNLOCK_LEN = DefUnlockLen,
  parameter logic [UNLOCK_LEN*8-1:0]      UNLOCK_SEQ = DefUnlockSeq,
  parameter bit                           STRICT     = 1'b0,
  parameter int unsigned                  BS_LEN     = DefBsLen,
  parameter logic [BS_LEN-1:0]            BS_PAT     = DefBsPat
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] addr_i,
  input  logic       cen_i,
  input  logic       relock_i,
  output logic       open_o,
  output logic       so_o
);

  localparam int unsigned StepW = (UNLOCK_LEN > 1) ? $clog2(UNLOCK_LEN) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(UNLOCK_LEN - 1);

  unlock_state_e     state_q, state_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [BS_LEN-1:0] sr_q, sr_d;
  logic              load;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load    = 1'b0;
    unique case (state_q)
      StLocked: begin
        if (addr_i == UNLOCK_SEQ[8*step_q +: 8]) begin
          if (step_q == LastStep) begin
            state_d = StOpen;
            step_d  = '0;
            load    = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else if (STRICT && !cen_i) begin
          step_d = '0;
        end
      end
      StOpen: begin
        if (relock_i) begin
          state_d = StLocked;
          step_d  = '0;
        end
      end
      default: state_d = StLocked;
    endcase
  end

  // Relock leaves the shift register running; only an unlock reloads it.
  assign sr_d = load ? BS_PAT : {1'b1, sr_q[BS_LEN-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StLocked;
      step_q  <= '0;
      sr_q    <= '1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sr_q    <= sr_d;
    end
  end

  assign open_o = (state_q == StOpen);
  assign so_o   = sr_q[0];

endmodule

// File: rtl/wsc_cart_mapper.sv
// Cartridge mapper top: bank/LAO/CTRL register file, readback, chip-enable and upper
// address decode, gated by the unlock sequencer.
module wsc_cart_mapper
  import wsc_mapper_pkg::*;
#(
  parameter int unsigned             NUM_ROM    = 2,
  parameter int unsigned             BANK_W     = 8,
  parameter int unsigned             RADDR_W    = 7,
  parameter int unsigned             UNLOCK_LEN = DefUnlockLen,
  parameter logic [UNLOCK_LEN*8-1:0] UNLOCK_SEQ = DefUnlockSeq,
  parameter bit                      STRICT     = 1'b0,
  parameter int unsigned             BS_LEN     = DefBsLen,
  parameter logic [BS_LEN-1:0]       BS_PAT     = DefBsPat,
  parameter logic [7:0]              REG_BASE   = 8'hC0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               OEn,
  input  logic               WEn,
  input  logic [7:0]         ADDR,
  input  logic [BANK_W-1:0]  DQ_I,
  output logic [BANK_W-1:0]  DQ_O,
  output logic               DQ_OE,
  output logic               SO,
  output logic               LOCKED,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR
);

  localparam int unsigned CtrlIdx = NUM_ROM + 2;

  logic              is_open;
  logic [7:0]        reg_off;
  logic              in_range, sel, rd_hit, wr_en, relock;
  logic [3:0]        window;
  logic              rce, ram_ce, rom_ce;
  logic [BANK_W-1:0] rd_data;

  logic [BANK_W-1:0] lao_q, lao_d;
  logic [BANK_W-1:0] ram_q, ram_d;
  logic [BANK_W-1:0] rom_q [NUM_ROM];
  logic [BANK_W-1:0] rom_d [NUM_ROM];
  logic              wp_q, wp_d;

  assign reg_off  = ADDR - REG_BASE;
  assign in_range = (ADDR >= REG_BASE) && (reg_off <= 8'(CtrlIdx));
  assign sel      = ~SSn | ~CEn;
  assign rd_hit   = sel & in_range & ~OEn & WEn;
  assign wr_en    = is_open & sel & in_range & OEn & ~WEn;
  assign relock   = wr_en & (reg_off == 8'(CtrlIdx)) & DQ_I[CtrlRelock];

  wsc_unlock_seq #(
    .UNLOCK_LEN (UNLOCK_LEN),
    .UNLOCK_SEQ (UNLOCK_SEQ),
    .STRICT     (STRICT),
    .BS_LEN     (BS_LEN),
    .BS_PAT     (BS_PAT)
  ) u_unlock (
    .clk_i    (CLK),
    .rst_ni   (RSTn),
    .addr_i   (ADDR),
    .cen_i    (CEn),
    .relock_i (relock),
    .open_o   (is_open),
    .so_o     (SO)
  );

  always_comb begin
    lao_d = lao_q;
    ram_d = ram_q;
    rom_d = rom_q;
    wp_d  = wp_q;
    if (wr_en) begin
      if (reg_off == 8'(RegLao)) begin
        lao_d = DQ_I;
      end else if (reg_off == 8'(RegRam)) begin
        ram_d = DQ_I;
      end else if (reg_off == 8'(CtrlIdx)) begin
        // A relock write leaves WP as it was.
        if (!DQ_I[CtrlRelock]) wp_d = DQ_I[CtrlWp];
      end else begin
        for (int k = 0; k < NUM_ROM; k++) begin
          if (reg_off == 8'(RegRom0 + k)) rom_d[k] = DQ_I;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lao_q <= '1;
      ram_q <= '1;
      wp_q  <= 1'b0;
      for (int k = 0; k < NUM_ROM; k++) rom_q[k] <= '1;
    end else begin
      lao_q <= lao_d;
      ram_q <= ram_d;
      wp_q  <= wp_d;
      for (int k = 0; k < NUM_ROM; k++) rom_q[k] <= rom_d[k];
    end
  end

  always_comb begin
    rd_data = '0;
    if (reg_off == 8'(RegLao)) begin
      rd_data = lao_q;
    end else if (reg_off == 8'(RegRam)) begin
      rd_data = ram_q;
    end else if (reg_off == 8'(CtrlIdx)) begin
      rd_data[CtrlWp] = wp_q;
    end else begin
      for (int k = 0; k < NUM_ROM; k++) begin
        if (reg_off == 8'(RegRom0 + k)) rd_data = rom_q[k];
      end
    end
  end

  assign DQ_OE = is_open & rd_hit;
  assign DQ_O  = DQ_OE ? rd_data : '0;

  assign window = ADDR[7:4];
  assign rce    = is_open & SSn & ~CEn;
  assign ram_ce = rce & (window == 4'd1) & ~(wp_q & ~WEn);
  assign rom_ce = rce & (window >= 4'd2);

  assign RAMCEn = ~ram_ce;
  assign ROMCEn = ~rom_ce;
  assign LOCKED = ~is_open;

  always_comb begin
    RADDR = '0;
    if (ram_ce) begin
      RADDR = ram_q[RADDR_W-1:0];
    end else if (rom_ce) begin
      if (window > 4'(NUM_ROM + 1)) begin
        RADDR = {lao_q[RADDR_W-5:0], window};
      end else begin
        for (int k = 0; k < NUM_ROM; k++) begin
          if (window == 4'(RegRom0 + k)) RADDR = rom_q[k][RADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_wsc_cart_mapper.sv
// Bench for wsc_cart_mapper: a lax and a strict instance on a shared bus, checked every
// cycle against a behavioural model plus directed checks.
module tb_wsc_cart_mapper;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       CEn = 1'b1, SSn = 1'b1, OEn = 1'b1, WEn = 1'b1;
  logic [7:0] ADDR = 8'h00, DQ_I = 8'h00;

  logic [7:0] dqo_w   [2];
  logic [6:0] raddr_w [2];
  logic       dqoe_w[2], so_w[2], locked_w[2], romce_w[2], ramce_w[2];

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = lax instance, 1 = strict instance.
  bit         mlocked [2];
  int         mstep   [2];
  int         mbs     [2];
  logic [7:0] mreg    [2][4];
  bit         mwp     [2];
  logic [7:0] seq     [2] = '{8'h5A, 8'hA5};
  logic [17:0] pat    = {1'b0, 16'h28A0, 1'b0};
  int         exp_so  [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};

  always #5 CLK = ~CLK;

  wsc_cart_mapper #(.STRICT(1'b0)) dut (
    .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .OEn(OEn), .WEn(WEn), .ADDR(ADDR),
    .DQ_I(DQ_I), .DQ_O(dqo_w[0]), .DQ_OE(dqoe_w[0]), .SO(so_w[0]), .LOCKED(locked_w[0]),
    .ROMCEn(romce_w[0]), .RAMCEn(ramce_w[0]), .RADDR(raddr_w[0])
  );

  wsc_cart_mapper #(.STRICT(1'b1)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .CEn(CEn), .SSn(SSn), .OEn(OEn), .WEn(WEn), .ADDR(ADDR),
    .DQ_I(DQ_I), .DQ_O(dqo_w[1]), .DQ_OE(dqoe_w[1]), .SO(so_w[1]), .LOCKED(locked_w[1]),
    .ROMCEn(romce_w[1]), .RAMCEn(ramce_w[1]), .RADDR(raddr_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mlocked[m] = 1'b1;
      mstep[m]   = 0;
      mbs[m]     = 18;
      mwp[m]     = 1'b0;
      for (int r = 0; r < 4; r++) mreg[m][r] = 8'hFF;
    end
  endtask

  task automatic model_edge();
    int  idx;
    bit  hit, loaded;
    for (int m = 0; m < 2; m++) begin
      loaded = 1'b0;
      idx    = int'(ADDR) - 'hC0;
      hit    = (!SSn || !CEn) && idx >= 0 && idx <= 4;
      if (!mlocked[m]) begin
        if (hit && OEn && !WEn) begin
          if (idx == 4) begin
            if (DQ_I[1]) begin
              mlocked[m] = 1'b1;
              mstep[m]   = 0;
            end else begin
              mwp[m] = DQ_I[0];
            end
          end else begin
            mreg[m][idx] = DQ_I;
          end
        end
      end else if (ADDR == seq[mstep[m]]) begin
        mstep[m]++;
        if (mstep[m] == 2) begin
          mlocked[m] = 1'b0;
          mstep[m]   = 0;
          mbs[m]     = 0;
          loaded     = 1'b1;
        end
      end else if (m == 1 && !CEn) begin
        mstep[m] = 0;
      end
      if (!loaded && mbs[m] < 18) mbs[m]++;
    end
  endtask

  task automatic check_all();
    int         idx, win;
    bit         hit, rd, oe, rce, ramce, romce;
    logic [7:0] dq;
    logic [6:0] ra;
    for (int m = 0; m < 2; m++) begin
      idx = int'(ADDR) - 'hC0;
      win = int'(ADDR[7:4]);
      hit = (!SSn || !CEn) && idx >= 0 && idx <= 4;
      rd  = hit && !OEn && WEn;
      oe  = !mlocked[m] && rd;
      dq  = 8'h00;
      if (oe) dq = (idx == 4) ? {7'b0, mwp[m]} : mreg[m][idx];
      rce   = !mlocked[m] && SSn && !CEn;
      ramce = rce && win == 1 && !(mwp[m] && !WEn);
      romce = rce && win >= 2;
      ra    = 7'h00;
      if (ramce) ra = mreg[m][1][6:0];
      else if (romce) ra = (win <= 3) ? mreg[m][win][6:0] : 7'({mreg[m][0][2:0], 4'(win)});
      chk($sformatf("m%0d_locked", m), 32'(locked_w[m]), 32'(mlocked[m]));
      chk($sformatf("m%0d_so", m), 32'(so_w[m]), (mbs[m] < 18) ? 32'(pat[mbs[m]]) : 32'd1);
      chk($sformatf("m%0d_dqoe", m), 32'(dqoe_w[m]), 32'(oe));
      chk($sformatf("m%0d_dqo", m), 32'(dqo_w[m]), 32'(dq));
      chk($sformatf("m%0d_ramcen", m), 32'(ramce_w[m]), 32'(!ramce));
      chk($sformatf("m%0d_romcen", m), 32'(romce_w[m]), 32'(!romce));
      chk($sformatf("m%0d_raddr", m), 32'(raddr_w[m]), 32'(ra));
    end
  endtask

  task automatic step(input logic cen, input logic ssn, input logic oen, input logic wen,
                      input logic [7:0] addr, input logic [7:0] dq);
    @(negedge CLK);
    CEn = cen; SSn = ssn; OEn = oen; WEn = wen; ADDR = addr; DQ_I = dq;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input logic [7:0] a);  step(1'b1, 1'b1, 1'b1, 1'b1, a, 8'h00); endtask
  task automatic io_wr(input logic [7:0] a, input logic [7:0] d); step(1'b1, 1'b0, 1'b1, 1'b0, a, d); endtask
  task automatic io_rd(input logic [7:0] a); step(1'b1, 1'b0, 1'b0, 1'b1, a, 8'h00); endtask
  task automatic mem_rd(input logic [7:0] a); step(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00); endtask
  task automatic mem_wr(input logic [7:0] a); step(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00); endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_so", 32'(so_w[0] & so_w[1]), 32'd1);
    chk("rst_locked", 32'(locked_w[0] & locked_w[1]), 32'd1);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  initial begin
    int op;
    logic [7:0] a, d;

    do_reset();
    chk("rst_romcen", 32'(romce_w[0]), 32'd1);

    // Locked: writes ignored, no readback, no chip enables.
    io_wr(8'hC2, 8'h12);
    io_rd(8'hC2);
    chk("locked_dqoe", 32'(dqoe_w[0]), 32'd0);
    mem_rd(8'h20);
    chk("locked_romcen", 32'(romce_w[0]), 32'd1);

    idle(8'h5A);
    idle(8'hA5);
    chk("unlock_locked", 32'(locked_w[0]), 32'd0);
    chk("so_bit0", 32'(so_w[0]), 32'(exp_so[0]));
    for (int j = 1; j < 18; j++) begin
      idle(8'h00);
      chk($sformatf("so_bit%0d", j), 32'(so_w[0]), 32'(exp_so[j]));
    end
    for (int j = 0; j < 3; j++) begin
      idle(8'h00);
      chk("so_tail", 32'(so_w[0]), 32'd1);
    end

    io_rd(8'hC2);
    chk("c2_reset_val", 32'(dqo_w[0]), 32'hFF);

    io_wr(8'hC2, 8'h12);
    mem_rd(8'h20);
    chk("rom0_cen", 32'(romce_w[0]), 32'd0);
    chk("rom0_raddr", 32'(raddr_w[0]), 32'h12);
    io_wr(8'hC0, 8'h05);
    mem_rd(8'h60);
    chk("linear_raddr", 32'(raddr_w[0]), 32'h56);

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 3));
      d  = 8'($urandom);
      case (op)
        0: io_wr(8'hC0 + 8'($urandom_range(0, 3)), d);
        1: io_wr(8'hC4, d & 8'hFD);
        2: io_rd(8'hC0 + 8'($urandom_range(0, 4)));
        default: begin
          a = {4'($urandom_range(0, 15)), 4'($urandom)};
          if ($urandom_range(0, 1) == 0) mem_rd(a);
          else mem_wr(a);
        end
      endcase
    end

    io_wr(8'hC2, 8'h12);
    io_wr(8'hC4, 8'h01);
    mem_rd(8'h10);
    chk("wp_ram_read", 32'(ramce_w[0]), 32'd0);
    mem_wr(8'h10);
    chk("wp_ram_write", 32'(ramce_w[0]), 32'd1);

    io_wr(8'hC4, 8'h02);
    chk("relock_locked", 32'(locked_w[0]), 32'd1);
    mem_rd(8'h20);
    chk("relock_romcen", 32'(romce_w[0]), 32'd1);

    // Interrupted sequence with CEn low: lax unlocks, strict restarts.
    idle(8'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 8'h00);
    idle(8'hA5);
    chk("lax_unlocked", 32'(locked_w[0]), 32'd0);
    chk("strict_locked", 32'(locked_w[1]), 32'd1);
    idle(8'h5A);
    idle(8'hA5);
    chk("strict_unlocked", 32'(locked_w[1]), 32'd0);
    io_rd(8'hC2);
    chk("c2_kept_lax", 32'(dqo_w[0]), 32'h12);
    chk("c2_kept_strict", 32'(dqo_w[1]), 32'h12);

    // Strict instance is mid-bitstream here.
    idle(8'h00);
    do_reset();
    idle(8'h5A);
    idle(8'hA5);
    io_rd(8'hC2);
    chk("c2_after_reset", 32'(dqo_w[0]), 32'hFF);
    io_rd(8'hC1);
    chk("ram_after_reset", 32'(dqo_w[1]), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
